// File: rtl/alu_ctrl_decoder_if.sv
// Handshake and result bundle between an instruction source and the
// ALU control decoder. The master drives instructions and consumes results;
// the slave is the decoder itself.
interface alu_ctrl_decoder_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       alu_ctrl;
    logic             src_imm;
    logic             branch;
    logic [31:0]      imm;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, alu_ctrl, src_imm, branch, imm,
               illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, alu_ctrl, src_imm, branch, imm,
               illegal, illegal_cnt
    );
endinterface

// File: rtl/alu_ctrl_decoder.sv
// RV32I/M ALU control decoder with a one-entry registered output stage.
// An accepted instruction word is decoded combinationally and captured into
// the output register; the result is held until consumed, replaced, flushed
// or reset. Accepted illegal instructions are counted (saturating).
module alu_ctrl_decoder #(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    alu_ctrl_decoder_if.slave bus
);

    // ALU operation codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_LST  = 4'b0100;
    localparam logic [3:0] ALU_GTE  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_NEQ  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_UMUL = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_LSTU = 4'b1100;
    localparam logic [3:0] ALU_GTEU = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1110;
    localparam logic [3:0] ALU_SLT  = 4'b1111;

    // Major opcodes
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef struct packed {
        logic [3:0]  alu;
        logic        src_imm;
        logic        branch;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    // Base register/immediate operation selected by funct3 alone
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Full decode of one instruction word; illegal words collapse to a
    // result with every field zero except the illegal flag.
    function automatic dec_t decode_instr(input logic [31:0] ins);
        dec_t        r;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_b;
        logic [31:0] imm_u;
        logic [31:0] imm_j;

        op    = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_u = {ins[31:12], 12'h000};
        imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        r     = '0;

        case (op)
            OP_REG: begin
                case (f7)
                    F7_BASE: r.alu = base_op(f3);
                    F7_ALT: begin
                        if (f3 == 3'b000)      r.alu = ALU_SUB;
                        else if (f3 == 3'b101) r.alu = ALU_SRA;
                        else                   r.illegal = 1'b1;
                    end
                    F7_MUL: begin
                        if (f3 == 3'b000) r.alu = ALU_UMUL;
                        else              r.illegal = 1'b1;
                    end
                    default: r.illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                r.src_imm = 1'b1;
                r.imm     = imm_i;
                // Only the shift forms constrain funct7 (it is the shamt's upper field)
                if (f3 == 3'b001) begin
                    if (f7 == F7_BASE) r.alu = ALU_SLL;
                    else               r.illegal = 1'b1;
                end else if (f3 == 3'b101) begin
                    case (f7)
                        F7_BASE: r.alu = ALU_SRL;
                        F7_ALT:  r.alu = ALU_SRA;
                        default: r.illegal = 1'b1;
                    endcase
                end else begin
                    r.alu = base_op(f3);
                end
            end
            OP_LOAD, OP_JALR: begin
                r.alu = ALU_ADD; r.src_imm = 1'b1; r.imm = imm_i;
            end
            OP_STORE: begin
                r.alu = ALU_ADD; r.src_imm = 1'b1; r.imm = imm_s;
            end
            OP_LUI, OP_AUIPC: begin
                r.alu = ALU_ADD; r.src_imm = 1'b1; r.imm = imm_u;
            end
            OP_JAL: begin
                r.alu = ALU_ADD; r.src_imm = 1'b1; r.imm = imm_j;
            end
            OP_BRANCH: begin
                r.branch = 1'b1;
                r.imm    = imm_b;
                case (f3)
                    3'b000:  r.alu = ALU_SUB;   // BEQ resolves on the zero flag
                    3'b001:  r.alu = ALU_NEQ;
                    3'b100:  r.alu = ALU_LST;
                    3'b101:  r.alu = ALU_GTE;
                    3'b110:  r.alu = ALU_LSTU;
                    3'b111:  r.alu = ALU_GTEU;
                    default: r.illegal = 1'b1;
                endcase
            end
            default: r.illegal = 1'b1;
        endcase

        if (r.illegal) begin
            r         = '0;
            r.illegal = 1'b1;
        end else begin
            r.illegal = 1'b0;
        end
        return r;
    endfunction

    dec_t             dec_d;
    dec_t             dec_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] illegal_cnt_q;
    logic             in_ready_s;
    logic             capture_s;

    // Decode the presented word every cycle; it is only used on capture
    always_comb begin
        dec_d = decode_instr(bus.instr);
    end

    // One-entry output stage: accept whenever empty or being drained
    always_comb begin
        in_ready_s = 1'b0;
        capture_s  = 1'b0;
        in_ready_s = !out_valid_q || bus.out_ready;
        capture_s  = bus.in_valid && in_ready_s && !bus.flush;
    end

    // Output register and illegal counter; flush wins over capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            dec_q         <= '0;
            illegal_cnt_q <= '0;
        end else if (bus.flush) begin
            out_valid_q   <= 1'b0;
        end else if (capture_s) begin
            out_valid_q <= 1'b1;
            dec_q       <= dec_d;
            if (dec_d.illegal && (illegal_cnt_q != {CNT_W{1'b1}})) begin
                illegal_cnt_q <= illegal_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                illegal_cnt_q <= illegal_cnt_q;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_q;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_q;
    assign bus.alu_ctrl    = dec_q.alu;
    assign bus.src_imm     = dec_q.src_imm;
    assign bus.branch      = dec_q.branch;
    assign bus.imm         = dec_q.imm;
    assign bus.illegal     = dec_q.illegal;
    assign bus.illegal_cnt = illegal_cnt_q;

endmodule
